stencil_stream_ctrl: RTL and testbench

STENCIL_STREAM_CTRL -- requirements
Module: stencil_stream_ctrl

---
 rtl/stencil_stream_ctrl.sv | 142 ++++++++++++++
 tb/tb_stencil_stream_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stencil_stream_ctrl.sv
// Flow controller for a SIZE x SIZE stencil pipeline: fills the line buffer, streams
// windows downstream, flushes with zeros, and repeats for num_iter passes.
module stencil_stream_ctrl #(
  parameter int SIZE       = 512,
  parameter int ITER_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ITER_WIDTH-1:0] num_iter,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  shift_en,
  output logic                  flush_sel,
  output logic [31:0]           valid_data_counter,
  output logic [ITER_WIDTH-1:0] iter_count,
  output logic                  busy,
  output logic                  done
);

  localparam logic [31:0] L_ROW   = 32'(SIZE);
  localparam logic [31:0] L_FIRST = 32'(SIZE + 1);
  localparam logic [31:0] L_AREA  = 32'(SIZE * SIZE);
  localparam logic [31:0] L_END   = 32'(SIZE * SIZE + SIZE);

  typedef enum logic [2:0] {IDLE, FILL, RUN, FLUSH, LAST} state_t;

  state_t                r_state, w_next_state;
  logic [31:0]           r_cnt;
  logic [ITER_WIDTH-1:0] r_iter;
  logic [ITER_WIDTH-1:0] r_num;
  logic                  r_m_valid;
  logic                  r_done;

  logic                  w_out_free;
  logic                  w_s_ready;
  logic                  w_shift;
  logic                  w_flush;
  logic                  w_accept_start;
  logic                  w_pass_restart;
  logic                  w_run_done;
  logic [31:0]           w_cnt_next;
  logic [ITER_WIDTH:0]   w_iter_inc;

  assign w_out_free = !r_m_valid || m_ready;
  assign w_cnt_next = r_cnt + 32'd1;
  assign w_iter_inc = {1'b0, r_iter} + {{ITER_WIDTH{1'b0}}, 1'b1};

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
  always_comb begin
    w_next_state   = r_state;
    w_s_ready      = 1'b0;
    w_shift        = 1'b0;
    w_flush        = 1'b0;
    w_accept_start = 1'b0;
    w_pass_restart = 1'b0;
    w_run_done     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept_start = 1'b1;
          w_next_state   = FILL;
        end
      end
      FILL: begin
        w_s_ready = 1'b1;
        w_shift   = s_valid;
        if (w_shift && w_cnt_next == L_ROW) w_next_state = RUN;
      end
      RUN: begin
        w_s_ready = w_out_free;
        w_shift   = s_valid && w_out_free;
        if (w_shift && w_cnt_next == L_AREA) w_next_state = FLUSH;
      end
      FLUSH: begin
        w_flush = 1'b1;
        w_shift = w_out_free;
        if (w_shift && w_cnt_next == L_END) w_next_state = LAST;
      end
      LAST: begin
        // The final window of the pass must be consumed before restarting or finishing.
        if (r_m_valid && m_ready) begin
          if (w_iter_inc < {1'b0, r_num}) begin
            w_pass_restart = 1'b1;
            w_next_state   = FILL;
          end else begin
            w_run_done   = 1'b1;
            w_next_state = IDLE;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_iter    <= '0;
      r_num     <= '0;
      r_m_valid <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      if (w_accept_start) begin
        r_cnt  <= '0;
        r_iter <= '0;
        r_num  <= (num_iter == '0) ? ITER_WIDTH'(1) : num_iter;
      end else if (w_pass_restart) begin
        r_cnt  <= '0;
        r_iter <= w_iter_inc[ITER_WIDTH-1:0];
      end else if (w_shift) begin
        r_cnt <= w_cnt_next;
      end

      // A window exists once a full row plus one element has entered the buffer.
      if (w_shift && w_cnt_next >= L_FIRST && w_cnt_next <= L_END) r_m_valid <= 1'b1;
      else if (m_ready)                                             r_m_valid <= 1'b0;

      r_done <= w_run_done;
    end
  end

  assign s_ready            = w_s_ready;
  assign shift_en           = w_shift;
  assign flush_sel          = w_flush;
  assign m_valid            = r_m_valid;
  assign m_last             = r_m_valid && (r_cnt == L_END);
  assign valid_data_counter = r_cnt;
  assign iter_count         = r_iter;
  assign busy               = (r_state != IDLE);
  assign done               = r_done;

endmodule

// File: tb/tb_stencil_stream_ctrl.sv
// Bench for stencil_stream_ctrl at SIZE=4: directed table runs, corner sequences and
// randomized runs, all scored against a window-sequence model built from pass arithmetic.
module tb_stencil_stream_ctrl;
  localparam int SIZE     = 4;
  localparam int IW       = 8;
  localparam int AREA     = SIZE * SIZE;
  localparam int LAST_CNT = AREA + SIZE;

  logic          clk = 1'b0;
  logic          rst, start, s_valid, m_ready;
  logic [IW-1:0] num_iter;
  logic          s_ready, m_valid, m_last, shift_en, flush_sel, busy, done;
  logic [31:0]   valid_data_counter;
  logic [IW-1:0] iter_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stencil_stream_ctrl #(.SIZE(SIZE), .ITER_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_iter(num_iter),
    .s_valid(s_valid), .s_ready(s_ready), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .shift_en(shift_en), .flush_sel(flush_sel),
    .valid_data_counter(valid_data_counter), .iter_count(iter_count),
    .busy(busy), .done(done)
  );

  typedef struct { int cnt; int pass; bit last; } win_t;
  typedef struct {
    logic [IW-1:0] n;
    int            sv_mode;
    int            mr_mode;
    bit            inject;
    int            exp_win;
    int            exp_acc;
    string         tag;
  } vec_t;

  win_t exp_q[$];
  vec_t vecs[6];

  bit   prev_shift, prev_mv, prev_mr, first_seen;
  int   prev_cnt, prev_iter;
  int   windows, accepts, dones, cyc, last_hs_cyc, done_cyc;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic pick(input int mode, input int idx);
    case (mode)
      0:       return 1'b1;
      1:       return (idx % 2) == 0;
      2:       return $urandom_range(0, 3) != 0;
      default: return 1'b1;
    endcase
  endfunction

  task automatic clear_monitor();
    prev_shift = 0; prev_mv = 0; prev_mr = 0; prev_cnt = 0; prev_iter = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_last"}, m_last, 0);
    check({tag, "_shift_en"}, shift_en, 0);
    check({tag, "_flush_sel"}, flush_sel, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_counter"}, valid_data_counter, 0);
    check({tag, "_iter"}, iter_count, 0);
  endtask

  // Called mid-cycle, after inputs settle; scores the current cycle's outputs.
  task automatic observe();
    if (m_valid && !first_seen) begin
      first_seen = 1;
      check("first_window_cnt", valid_data_counter, SIZE + 1);
    end
    if (prev_shift && prev_cnt + 1 >= SIZE + 1 && prev_cnt + 1 <= LAST_CNT) begin
      check("latency_mvalid", m_valid, 1);
      check("latency_cnt", valid_data_counter, prev_cnt + 1);
    end
    if (prev_mv && !prev_mr) begin
      check("hold_mvalid", m_valid, 1);
      check("hold_cnt", valid_data_counter, prev_cnt);
    end
    if (m_valid)
      check("mvalid_range", (valid_data_counter >= SIZE + 1) && (valid_data_counter <= LAST_CNT), 1);
    check("m_last", m_last, m_valid && (valid_data_counter == LAST_CNT));
    if (flush_sel) check("flush_blocks_upstream", s_ready, 0);
    if (busy && int'(iter_count) != prev_iter) check("cnt_restart", valid_data_counter, 0);
    if (s_valid && s_ready) begin
      accepts++;
      check("shift_on_accept", shift_en, 1);
    end
    if (m_valid && m_ready) begin
      windows++;
      if (m_last) last_hs_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("extra_window", 1, 0);
      end else begin
        win_t w = exp_q.pop_front();
        check("win_cnt", valid_data_counter, w.cnt);
        check("win_iter", iter_count, w.pass);
        check("win_last", m_last, w.last);
      end
    end
    if (done) begin
      dones++;
      done_cyc = cyc;
    end
    prev_shift = shift_en;
    prev_cnt   = int'(valid_data_counter);
    prev_mv    = m_valid;
    prev_mr    = m_ready;
    prev_iter  = int'(iter_count);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1; start = 0; s_valid = 0; m_ready = 0; num_iter = '0;
    next_cycle();
    rst = 0;
    clear_monitor();
  endtask

  task automatic run_pass(input logic [IW-1:0] n, input int sv_mode, input int mr_mode,
                          input bit inject, input int exp_win, input int exp_acc, input string tag);
    int neff   = (n == 0) ? 1 : int'(n);
    int stalls = 0;
    int budget = 0;
    bit finished = 0;
    exp_q.delete();
    for (int p = 0; p < neff; p++)
      for (int k = SIZE + 1; k <= LAST_CNT; k++)
        exp_q.push_back('{k, p, k == LAST_CNT});
    windows = 0; accepts = 0; dones = 0; first_seen = 0; last_hs_cyc = -1; done_cyc = -2;

    start = 1; num_iter = n; s_valid = 0; m_ready = 1;
    #1;
    check({tag, "_idle_before_start"}, busy, 0);
    observe();
    next_cycle();
    start = 0;
    num_iter = IW'($urandom);
    check({tag, "_busy_after_start"}, busy, 1);

    while (!finished && budget < 3000) begin
      s_valid = pick(sv_mode, budget);
      m_ready = pick(mr_mode, budget);
      if (mr_mode == 3 && m_valid && valid_data_counter == 9 && stalls < 3) begin
        m_ready = 0;
        stalls++;
      end
      if (inject && budget == 10) begin
        start = 1; num_iter = 5;
      end else begin
        start = 0;
      end
      #1;
      if (mr_mode == 3 && !m_ready && m_valid) begin
        check({tag, "_stall_mvalid"}, m_valid, 1);
        check({tag, "_stall_cnt"}, valid_data_counter, 9);
        check({tag, "_stall_s_ready"}, s_ready, 0);
        check({tag, "_stall_shift"}, shift_en, 0);
      end
      observe();
      if (done) finished = 1;
      next_cycle();
      budget++;
    end
    start = 0;
    if (!finished) check({tag, "_timeout"}, 0, 1);
    check({tag, "_windows"}, windows, exp_win);
    check({tag, "_accepts"}, accepts, exp_acc);
    check({tag, "_done_pulses"}, dones, 1);
    check({tag, "_done_after_last"}, done_cyc, last_hs_cyc + 1);
    check({tag, "_queue_left"}, exp_q.size(), 0);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_done_one_cycle"}, done, 0);
    if (mr_mode == 3) check({tag, "_stall_cycles"}, stalls, 3);
  endtask

  initial begin
    vecs[0] = '{8'd1, 0, 0, 1'b0, 16, 16, "basic"};
    vecs[1] = '{8'd1, 0, 3, 1'b0, 16, 16, "stall9"};
    vecs[2] = '{8'd1, 1, 0, 1'b0, 16, 16, "toggle_sv"};
    vecs[3] = '{8'd3, 0, 0, 1'b0, 48, 48, "three_iter"};
    vecs[4] = '{8'd0, 0, 0, 1'b1, 16, 16, "zero_iter"};
    vecs[5] = '{8'd2, 2, 2, 1'b0, 32, 32, "rand_two"};

    cyc = 0;
    clear_monitor();
    do_reset();
    check_reset_outputs("reset");

    for (int i = 0; i < 6; i++)
      run_pass(vecs[i].n, vecs[i].sv_mode, vecs[i].mr_mode, vecs[i].inject,
               vecs[i].exp_win, vecs[i].exp_acc, vecs[i].tag);

    // Reset in the middle of the flush phase, then a clean pass.
    begin
      int  budget  = 0;
      start = 1; num_iter = 1; s_valid = 1; m_ready = 1;
      next_cycle();
      start = 0;
      while (valid_data_counter != 18 && budget < 200) begin
        next_cycle();
        budget++;
      end
      check("midrst_reached_18", valid_data_counter, 18);
      check("midrst_in_flush", flush_sel, 1);
      rst = 1;
      next_cycle();
      rst = 0;
      clear_monitor();
      check_reset_outputs("midrst");
      run_pass(8'd1, 0, 0, 1'b0, 16, 16, "after_rst");
    end

    for (int r = 0; r < 6; r++) begin
      logic [IW-1:0] n = IW'($urandom_range(0, 3));
      int neff = (n == 0) ? 1 : int'(n);
      run_pass(n, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0,
               neff * AREA, neff * AREA, $sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
